// File: rtl/seg7_pkg.sv
// Shared types, constants and the digit-search helper for the
// seven-segment scan scheduler.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ON,
        S_OFF
    } state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low {dp,g,f,e,d,c,b,a} patterns for hex 0..F, dp held off.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Next enabled digit after cur, searching upward modulo 4. Returns cur
    // when it is the only enabled digit. Calling it with cur=3 yields the
    // lowest enabled digit.
    function automatic logic [1:0] next_enabled(input logic [3:0] en,
                                                input logic [1:0] cur);
        logic [1:0] idx;
        next_enabled = cur;
        for (int k = 4; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (en[idx]) next_enabled = idx;
        end
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern (no dp).
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[hex_i][6:0];

endmodule

// File: rtl/seg7_scan_scheduler.sv
// Scan scheduler for a 4-digit common-anode display: blank/PWM slot timing,
// rotation over enabled digits and tear-free commit of new data per frame.
module seg7_scan_scheduler
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS = 4096,
    parameter int BLANK_TICKS = 64
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        wr_valid,
    input  logic [19:0] wr_data,
    output logic        wr_ready,
    input  logic [3:0]  dig_en,
    input  logic [3:0]  bright,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [1:0]  cur_digit,
    output logic        frame_done
);

    localparam int TW     = $clog2(DIGIT_TICKS);
    localparam int ACTIVE = DIGIT_TICKS - BLANK_TICKS;
    localparam int PW     = TW + 4;

    state_e        state_q;
    logic [TW-1:0] tick_q, on_len_q, on_len_d, on_cnt_next;
    logic [1:0]    sel_q, next_sel, first_sel, cur_digit_q;
    logic [3:0]    an_q;
    logic [7:0]    seg_q;
    logic [PW-1:0] on_prod;
    logic          slot_end, boundary;
    logic [19:0]   active_q, pending_q;
    logic          pending_full_q, pending_full_d, wr_ready_q, frame_done_q, wr_xfer;
    logic [3:0]    hex_sel, dp_bits;
    logic [6:0]    seg7;

    // (bright+1)*ACTIVE needs TW+4 bits; the shift happens only afterwards.
    assign on_prod     = (PW'(bright) + PW'(1)) * PW'(ACTIVE);
    assign on_len_d    = TW'(on_prod >> 4);
    assign on_cnt_next = tick_q - TW'(BLANK_TICKS - 1);

    assign hex_sel = active_q[{sel_q, 2'b00} +: 4];
    assign dp_bits = active_q[19:16];
    assign wr_xfer = wr_valid & wr_ready_q;

    hex_to_seg7 u_hex (
        .hex_i (hex_sel),
        .seg_o (seg7)
    );

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        slot_end  = (state_q != S_IDLE) && (tick_q == TW'(DIGIT_TICKS - 1));
        next_sel  = next_enabled(dig_en, sel_q);
        first_sel = next_enabled(dig_en, 2'd3);
        boundary  = 1'b0;
        if (state_q == S_IDLE) begin
            boundary = (dig_en != 4'd0);
        end else if (slot_end) begin
            boundary = (dig_en != 4'd0) && (next_sel <= sel_q);
        end
        pending_full_d = wr_xfer | (pending_full_q & ~boundary);
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            sel_q       <= '0;
            on_len_q    <= '0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            cur_digit_q <= '0;
        end else begin
            // NOTE: non-blocking so every read in this block sees the pre-edge value.
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            cur_digit_q <= sel_q;
            if (state_q == S_ON) begin
                an_q  <= ~(4'b0001 << sel_q);
                seg_q <= {~dp_bits[sel_q], seg7};
            end

            if (state_q == S_IDLE) begin
                if (dig_en != 4'd0) begin
                    sel_q   <= first_sel;
                    tick_q  <= '0;
                    state_q <= S_BLANK;
                end
            end else if (slot_end) begin
                tick_q <= '0;
                if (dig_en == 4'd0) begin
                    state_q <= S_IDLE;
                end else begin
                    sel_q   <= next_sel;
                    state_q <= S_BLANK;
                end
            end else begin
                tick_q <= tick_q + TW'(1);
                case (state_q)
                    S_BLANK: begin
                        if (tick_q == '0) on_len_q <= on_len_d;
                        if (tick_q == TW'(BLANK_TICKS - 1)) state_q <= S_ON;
                    end
                    S_ON: if (on_cnt_next == on_len_q) state_q <= S_OFF;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q       <= '0;
            pending_full_q <= 1'b0;
            wr_ready_q     <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            frame_done_q   <= boundary;
            pending_full_q <= pending_full_d;
            wr_ready_q     <= ~pending_full_d;
            if (boundary && pending_full_q) active_q <= pending_q;
        end
    end

    // NOTE: payload register needs no reset; pending_full_q qualifies it.
    always_ff @(posedge Clk) begin
        if (wr_xfer) pending_q <= wr_data;
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign cur_digit  = cur_digit_q;
    assign frame_done = frame_done_q;
    assign wr_ready   = wr_ready_q;

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Scoreboard bench: a slot-level reference model queues expected lit episodes,
// a monitor reassembles episodes from an/seg and compares them.
module tb_seg7_scan_scheduler;

    localparam int DT  = 16;
    localparam int BT  = 4;
    localparam int ACT = DT - BT;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [19:0] wr_data = '0;
    logic [3:0]  dig_en = 4'h0;
    logic [3:0]  bright = 4'h0;
    logic        wr_ready;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  cur_digit;
    logic        frame_done;

    always #5 Clk = ~Clk;

    seg7_scan_scheduler #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
        .Clk        (Clk),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .dig_en     (dig_en),
        .bright     (bright),
        .an         (an),
        .seg        (seg),
        .cur_digit  (cur_digit),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic [1:0] dig;
        int         len;
        int         frame;
    } ep_t;

    ep_t exp_q[$];
    logic [7:0] seg_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lowest_on(input logic [3:0] en);
        for (int i = 0; i < 4; i++) if (en[i]) return i;
        return 0;
    endfunction

    function automatic int next_on(input logic [3:0] en, input int from);
        for (int k = 1; k <= 4; k++) if (en[(from + k) % 4]) return (from + k) % 4;
        return from;
    endfunction

    // Reference model: slot-level schedule, one expected episode per slot.
    bit          m_busy, m_frame, m_full;
    int          m_tick, m_dig;
    logic [19:0] m_active, m_pend;

    initial begin : model
        bit  bnd, xfer;
        ep_t e;
        m_busy = 0; m_frame = 0; m_full = 0; m_tick = 0; m_dig = 0;
        m_active = '0; m_pend = '0;
        forever begin
            @(posedge Clk or negedge reset_n);
            if (!reset_n) begin
                m_busy = 0; m_frame = 0; m_full = 0; m_tick = 0; m_dig = 0;
                m_active = '0;
                exp_q.delete();
            end else begin
                bnd  = 0;
                xfer = wr_valid && !m_full;
                if (m_busy && m_tick == 0) begin
                    e.dig   = 2'(m_dig);
                    e.an    = 4'hF ^ (4'b0001 << m_dig);
                    e.seg   = {~m_active[16 + m_dig], seg_tab[m_active[4*m_dig +: 4]][6:0]};
                    e.len   = ((int'(bright) + 1) * ACT) >> 4;
                    e.frame = m_frame ? 1 : 0;
                    m_frame = 0;
                    exp_q.push_back(e);
                end
                if (!m_busy) begin
                    if (dig_en != 0) begin
                        bnd = 1; m_busy = 1; m_tick = 0; m_dig = lowest_on(dig_en);
                    end
                end else if (m_tick == DT - 1) begin
                    m_tick = 0;
                    if (dig_en == 0) begin
                        m_busy = 0;
                    end else begin
                        bnd   = (next_on(dig_en, m_dig) <= m_dig);
                        m_dig = next_on(dig_en, m_dig);
                    end
                end else begin
                    m_tick++;
                end
                if (bnd) m_frame = 1;
                if (bnd && m_full) begin
                    m_active = m_pend;
                    m_full   = 0;
                end
                if (xfer) begin
                    m_pend = wr_data;
                    m_full = 1;
                end
            end
        end
    end

    // Monitor: reassembles lit episodes and pops the scoreboard on each one.
    bit         in_ep, ep_bad;
    logic [3:0] ep_an;
    logic [7:0] ep_seg;
    logic [1:0] ep_cur;
    int         ep_len, ep_fd, fd_cnt;

    initial begin : monitor
        ep_t e;
        in_ep = 0; fd_cnt = 0;
        forever begin
            @(negedge Clk);
            if (!reset_n) begin
                in_ep = 0; fd_cnt = 0;
            end else begin
                check("wr_ready", wr_ready, !m_full);
                if (frame_done) fd_cnt++;
                if (an == 4'hF) begin
                    check("seg_blank", seg, 8'hFF);
                    if (in_ep) begin
                        in_ep = 0;
                        if (exp_q.size() == 0) begin
                            check("unexpected_episode", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("ep_an", ep_an, e.an);
                            check("ep_seg", ep_seg, e.seg);
                            check("ep_cur_digit", ep_cur, e.dig);
                            check("ep_len", ep_len, e.len);
                            check("ep_frame_done", ep_fd, e.frame);
                            check("ep_stable", ep_bad, 0);
                        end
                    end
                end else begin
                    check("an_onehot", $countones(~an), 1);
                    if (!in_ep) begin
                        in_ep = 1; ep_bad = 0; ep_len = 1;
                        ep_an = an; ep_seg = seg; ep_cur = cur_digit;
                        ep_fd = fd_cnt; fd_cnt = 0;
                    end else begin
                        ep_len++;
                        if (an !== ep_an || seg !== ep_seg) ep_bad = 1;
                    end
                end
            end
        end
    end

    task automatic write(input logic [19:0] d);
        int n = 0;
        @(negedge Clk);
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && n < 300) begin
            @(negedge Clk);
            n++;
        end
        check("wr_accept", wr_ready, 1);
        @(negedge Clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_fd(input int budget);
        int n = 0;
        @(negedge Clk);
        while (!frame_done && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check("frame_done_wait", frame_done, 1);
    endtask

    task automatic wait_lit(input int budget);
        int n = 0;
        @(negedge Clk);
        while (an == 4'hF && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check("lit_wait", an != 4'hF, 1);
    endtask

    initial begin : stimulus
        longint t0;
        int     run;
        dig_en = 4'b1111;
        bright = 4'd15;
        repeat (2) @(negedge Clk);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 8'hFF);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_frame_done", frame_done, 0);
        check("rst_cur_digit", cur_digit, 0);
        reset_n = 1'b1;

        // Full brightness, all digits, data 1234 shown from the second frame.
        write(20'h0_1234);
        repeat (3 * 4 * DT) @(negedge Clk);

        // Dim setting, then a brightness change in the middle of a lit slot.
        bright = 4'd3;
        repeat (2 * DT) @(negedge Clk);
        wait_lit(2 * DT);
        run = 1;
        @(negedge Clk);
        while (an != 4'hF && run < DT) begin
            run++;
            @(negedge Clk);
        end
        check("on_len_b3", run, 3);
        wait_lit(2 * DT);
        bright = 4'd11;
        repeat (3 * DT) @(negedge Clk);

        // Two digits enabled: frames every two slots.
        bright = 4'd15;
        dig_en = 4'b0101;
        wait_fd(6 * DT);
        t0 = $time;
        wait_fd(6 * DT);
        check("frame_period", int'(($time - t0) / 10), 2 * DT);
        repeat (2 * DT) @(negedge Clk);

        // Disable mid-slot, then re-enable.
        wait_lit(2 * DT);
        dig_en = 4'b0000;
        repeat (DT + 3) @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            check("idle_an", an, 4'hF);
            check("idle_seg", seg, 8'hFF);
            repeat (3) @(negedge Clk);
        end
        dig_en = 4'b0110;
        wait_fd(8);
        wait_lit(2 * DT);
        check("restart_an", an, 4'b1101);
        check("restart_cur", cur_digit, 1);

        // Back-to-back writes, then a write landing exactly on a boundary.
        dig_en = 4'b1111;
        repeat (6 * DT) @(negedge Clk);
        write(20'h0_AAAA);
        check("ready_drop", wr_ready, 0);
        write(20'h0_BBBB);
        wait_fd(6 * DT);
        repeat (4 * DT - 2) @(negedge Clk);
        write(20'h0_CCCC);
        check("boundary_write_pending", wr_ready, 0);
        repeat (3 * 4 * DT) @(negedge Clk);

        // Reset in the middle of a lit slot with a write pending.
        write(20'h0_5555);
        wait_lit(2 * DT);
        #2 reset_n = 1'b0;
        #1;
        check("async_an", an, 4'hF);
        check("async_seg", seg, 8'hFF);
        check("async_wr_ready", wr_ready, 1);
        check("async_frame_done", frame_done, 0);
        check("async_cur_digit", cur_digit, 0);
        repeat (2) @(negedge Clk);
        reset_n = 1'b1;
        repeat (2 * 4 * DT) @(negedge Clk);

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(1, 40)) @(negedge Clk);
            case ($urandom_range(0, 3))
                0: bright = 4'($urandom);
                1: dig_en = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                default: begin
                    if (dig_en == 4'h0) dig_en = 4'($urandom_range(1, 15));
                    write(20'($urandom));
                end
            endcase
        end

        dig_en = 4'h0;
        repeat (2 * DT + 4) @(negedge Clk);
        check("end_queue_empty", exp_q.size(), 0);
        check("end_no_episode", in_ep, 0);
        check("end_an", an, 4'hF);
        check("end_seg", seg, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
